// File: rtl/pipe_field.sv
// Scrolling 16x16 pipe playfield: shifts columns left on tick, spawns pipes, detects crash, counts score.
// Latency: state updates on the sampling clk edge; pipeReq is a registered pulse one cycle after consumption.
// Backpressure: none; the generator must present a valid newPipe whenever a spawn can occur.
//
// Ports:
//   clk, reset (async active-low)  - clock and reset
//   start, tick                    - game (re)start pulse and scroll strobe
//   newPipe[15:0], birdRow[3:0]    - next pipe column from generator, current bird row
//   rdCol[3:0] -> rdData[15:0]     - combinational column read port for the LED scanner
//   pipeReq, running, crashed      - generator advance pulse and game state flags
//   score[7:0]                     - saturating count of pipes passed
module pipe_field #(
  parameter int COLS     = 16,
  parameter int GAP_COLS = 3,
  parameter int BIRD_COL = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        tick,
  input  logic [15:0] newPipe,
  input  logic [3:0]  birdRow,
  input  logic [3:0]  rdCol,
  output logic [15:0] rdData,
  output logic        pipeReq,
  output logic        running,
  output logic        crashed,
  output logic [7:0]  score
);

  localparam logic [3:0] GAP_INIT = 4'(GAP_COLS);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RUN     = 2'd1,
    ST_CRASHED = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] cols_q [COLS];
  logic [15:0] cols_d [COLS];
  logic [3:0]  space_q, space_d;
  logic [7:0]  score_q, score_d;
  logic        pipe_req_q, pipe_req_d;
  logic        hit;

  // Collision is checked every cycle in RUN, not only on ticks, so a bird
  // moving into a lit cell crashes immediately.
  always_comb begin
    hit = (state_q == ST_RUN) && cols_q[BIRD_COL][birdRow];
  end

  always_comb begin
    state_d    = state_q;
    cols_d     = cols_q;
    space_d    = space_q;
    score_d    = score_q;
    pipe_req_d = 1'b0;

    unique case (state_q)
      ST_IDLE, ST_CRASHED: begin
        // start takes priority; tick is ignored outside RUN.
        if (start) begin
          state_d = ST_RUN;
          for (int i = 0; i < COLS; i++) begin
            cols_d[i] = 16'h0000;
          end
          space_d = GAP_INIT;
          score_d = 8'd0;
        end
      end
      ST_RUN: begin
        if (hit) begin
          // Freeze on crash: no shift, no score, no spawn even with tick.
          state_d = ST_CRASHED;
        end else if (tick) begin
          // Score on the column leaving the bird position, before the shift.
          if ((cols_q[BIRD_COL] != 16'h0000) && (score_q != 8'hFF)) begin
            score_d = score_q + 8'd1;
          end
          for (int i = 0; i < COLS - 1; i++) begin
            cols_d[i] = cols_q[i + 1];
          end
          if (space_q == 4'd0) begin
            cols_d[COLS - 1] = newPipe;
            space_d          = GAP_INIT;
            pipe_req_d       = 1'b1;
          end else begin
            cols_d[COLS - 1] = 16'h0000;
            space_d          = space_q - 4'd1;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      for (int i = 0; i < COLS; i++) begin
        cols_q[i] <= 16'h0000;
      end
      space_q    <= GAP_INIT;
      score_q    <= 8'd0;
      pipe_req_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cols_q     <= cols_d;
      space_q    <= space_d;
      score_q    <= score_d;
      pipe_req_q <= pipe_req_d;
    end
  end

  // Read table padded to the full 4-bit index range; indices past the last
  // column read as empty.
  logic [15:0] rd_tbl [16];

  for (genvar g = 0; g < 16; g++) begin : g_rd
    if (g < COLS) begin : g_col
      assign rd_tbl[g] = cols_q[g];
    end else begin : g_pad
      assign rd_tbl[g] = 16'h0000;
    end
  end

  assign rdData  = rd_tbl[rdCol];
  assign pipeReq = pipe_req_q;
  assign running = (state_q == ST_RUN);
  assign crashed = (state_q == ST_CRASHED);
  assign score   = score_q;

endmodule

// File: tb/tb_pipe_field.sv
// Self-checking bench for pipe_field: reference model feeds a scoreboard queue,
// plus directed checks of the documented spawn, score, crash and restart timing.
// Inputs are driven 1ns after posedge; outputs sampled at the same point.
module tb_pipe_field;

  localparam int          BIRD = 3;
  localparam logic [15:0] PIPE = 16'hF01F;

  logic        clk;
  logic        reset;
  logic        start;
  logic        tick;
  logic [15:0] newPipe;
  logic [3:0]  birdRow;
  logic [3:0]  rdCol;
  logic [15:0] rdData;
  logic        pipeReq;
  logic        running;
  logic        crashed;
  logic [7:0]  score;

  pipe_field #(.COLS(16), .GAP_COLS(3), .BIRD_COL(3)) dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .tick    (tick),
    .newPipe (newPipe),
    .birdRow (birdRow),
    .rdCol   (rdCol),
    .rdData  (rdData),
    .pipeReq (pipeReq),
    .running (running),
    .crashed (crashed),
    .score   (score)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_total = 0;
  int n_bad   = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp_v);
    n_total++;
    if (act !== exp_v) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, act, exp_v);
    end
  endtask

  // Reference model (0 = idle, 1 = run, 2 = crashed).
  int          m_state;
  logic [15:0] m_col [16];
  logic [3:0]  m_space;
  logic [7:0]  m_score;

  typedef struct packed {
    logic        run;
    logic        crs;
    logic [7:0]  scr;
    logic        req;
    logic [15:0] dat;
  } exp_t;

  exp_t sb_q[$];

  task automatic model_reset();
    m_state = 0;
    for (int i = 0; i < 16; i++) m_col[i] = 16'h0000;
    m_space = 4'd3;
    m_score = 8'd0;
  endtask

  // Drive one cycle of stimulus, predict the outcome, then compare after the edge.
  task automatic step(input logic st, input logic tk, input logic [3:0] br,
                      input logic [15:0] np, input logic [3:0] rc);
    exp_t e;
    logic hit;
    logic req;
    start   = st;
    tick    = tk;
    birdRow = br;
    newPipe = np;
    rdCol   = rc;
    hit = (m_state == 1) && m_col[BIRD][br];
    req = 1'b0;
    if (m_state != 1) begin
      if (st) begin
        m_state = 1;
        for (int i = 0; i < 16; i++) m_col[i] = 16'h0000;
        m_space = 4'd3;
        m_score = 8'd0;
      end
    end else if (hit) begin
      m_state = 2;
    end else if (tk) begin
      if (m_col[BIRD] != 16'h0000 && m_score != 8'd255) m_score = m_score + 8'd1;
      for (int i = 0; i < 15; i++) m_col[i] = m_col[i + 1];
      if (m_space == 4'd0) begin
        m_col[15] = np;
        m_space   = 4'd3;
        req       = 1'b1;
      end else begin
        m_col[15] = 16'h0000;
        m_space   = m_space - 4'd1;
      end
    end
    e.run = (m_state == 1);
    e.crs = (m_state == 2);
    e.scr = m_score;
    e.req = req;
    e.dat = m_col[rc];
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    start = 1'b0;
    tick  = 1'b0;
    e = sb_q.pop_front();
    chk("sb_running", 32'(running), 32'(e.run));
    chk("sb_crashed", 32'(crashed), 32'(e.crs));
    chk("sb_score",   32'(score),   32'(e.scr));
    chk("sb_pipeReq", 32'(pipeReq), 32'(e.req));
    chk("sb_rdData",  32'(rdData),  32'(e.dat));
  endtask

  task automatic peek(input string tag, input logic [3:0] c, input logic [15:0] exp_v);
    rdCol = c;
    #1;
    chk(tag, 32'(rdData), 32'(exp_v));
  endtask

  initial begin
    reset   = 1'b0;
    start   = 1'b0;
    tick    = 1'b0;
    newPipe = 16'h0000;
    birdRow = 4'd0;
    rdCol   = 4'd0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_running", 32'(running), 32'd0);
    chk("rst_crashed", 32'(crashed), 32'd0);
    chk("rst_score",   32'(score),   32'd0);
    chk("rst_pipeReq", 32'(pipeReq), 32'd0);
    reset = 1'b1;

    // Tick in IDLE does nothing.
    step(1'b0, 1'b1, 4'd7, PIPE, 4'd15);
    chk("idle_tick_running", 32'(running), 32'd0);

    // Spawn cadence: first pipe on the 4th tick.
    step(1'b1, 1'b0, 4'd7, PIPE, 4'd15);
    chk("start_running", 32'(running), 32'd1);
    for (int t = 1; t <= 5; t++) begin
      step(1'b0, 1'b1, 4'd7, PIPE, 4'd15);
      chk($sformatf("spawn_req_t%0d", t), 32'(pipeReq), (t == 4) ? 32'd1 : 32'd0);
      if (t == 4) begin
        peek("spawn_col15", 4'd15, PIPE);
        peek("spawn_col14", 4'd14, 16'h0000);
      end
    end
    peek("spawn_col14_t5", 4'd14, PIPE);

    // Pass and score.
    for (int t = 6; t <= 16; t++) step(1'b0, 1'b1, 4'd7, PIPE, 4'd3);
    chk("pass_col3_t16", 32'(rdData), 32'(PIPE));
    chk("pass_score_t16", 32'(score), 32'd0);
    step(1'b0, 1'b1, 4'd7, PIPE, 4'd3);
    chk("pass_score_t17", 32'(score), 32'd1);
    chk("pass_running_t17", 32'(running), 32'd1);

    // Asynchronous reset mid-game with a nonzero field.
    rdCol = 4'd15;
    #2;
    reset = 1'b0;
    model_reset();
    #1;
    chk("arst_running", 32'(running), 32'd0);
    chk("arst_crashed", 32'(crashed), 32'd0);
    chk("arst_score",   32'(score),   32'd0);
    chk("arst_pipeReq", 32'(pipeReq), 32'd0);
    for (int c = 0; c < 16; c++) peek($sformatf("arst_col%0d", c), 4'(c), 16'h0000);
    reset = 1'b1;
    @(posedge clk);
    #1;

    // Collision with birdRow on a lit row.
    step(1'b1, 1'b0, 4'd0, PIPE, 4'd3);
    for (int t = 1; t <= 16; t++) step(1'b0, 1'b1, 4'd0, PIPE, 4'd3);
    chk("col_not_yet", 32'(crashed), 32'd0);
    step(1'b0, 1'b0, 4'd0, PIPE, 4'd3);
    chk("col_crashed", 32'(crashed), 32'd1);
    step(1'b0, 1'b1, 4'd0, PIPE, 4'd3);
    chk("col_frozen_col3", 32'(rdData), 32'(PIPE));
    chk("col_frozen_score", 32'(score), 32'd0);

    // Crash on the same cycle as a tick.
    step(1'b1, 1'b0, 4'd7, PIPE, 4'd3);
    for (int t = 1; t <= 16; t++) step(1'b0, 1'b1, 4'd7, PIPE, 4'd3);
    step(1'b0, 1'b1, 4'd0, PIPE, 4'd3);
    chk("ct_crashed", 32'(crashed), 32'd1);
    chk("ct_col3", 32'(rdData), 32'(PIPE));
    chk("ct_pipeReq", 32'(pipeReq), 32'd0);

    // Saturation: 300+ passes.
    step(1'b1, 1'b0, 4'd7, PIPE, 4'd3);
    for (int t = 1; t <= 1220; t++) step(1'b0, 1'b1, 4'd7, PIPE, 4'(t % 16));
    chk("sat_score", 32'(score), 32'd255);
    for (int k = 0; k < 40 && !crashed; k++) step(1'b0, 1'b1, 4'd0, PIPE, 4'd3);
    chk("sat_crash_reached", 32'(crashed), 32'd1);
    chk("sat_crash_score", 32'(score), 32'd255);

    // Restart from CRASHED with a simultaneous tick.
    step(1'b1, 1'b1, 4'd7, PIPE, 4'd15);
    chk("rs_running", 32'(running), 32'd1);
    chk("rs_score", 32'(score), 32'd0);
    chk("rs_pipeReq", 32'(pipeReq), 32'd0);
    for (int c = 0; c < 16; c++) peek($sformatf("rs_col%0d", c), 4'(c), 16'h0000);
    for (int t = 1; t <= 4; t++) begin
      step(1'b0, 1'b1, 4'd7, PIPE, 4'd15);
      chk($sformatf("rs_req_t%0d", t), 32'(pipeReq), (t == 4) ? 32'd1 : 32'd0);
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/pipe_field.md
# pipe_field

Scrolling playfield that consumes the 16-bit pipe columns produced by the pipe generator, stores a 16×16 LED image, and shifts it one column left per game tick. It requests a new pipe column after a fixed empty-column spacing, detects collision between the bird and lit cells, and counts passed pipes. It sits between the pipe generator/LFSR and the LED row-scan driver.

## Interface
- COLS, 16: number of playfield columns; column 0 is leftmost.
- GAP_COLS, 3: empty columns inserted between consecutive pipes, range 1–15.
- BIRD_COL, 3: fixed column occupied by the bird, range 1 to COLS-2.
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  single-cycle pulse; begins or restarts a game.
- tick  in  1  single-cycle scroll strobe.
- newPipe  in  16  next pipe column from the generator; bit i lights row i.
- birdRow  in  4  current bird row.
- rdCol  in  4  column index for the LED driver read port.
- rdData  out  16  combinational contents of column rdCol.
- pipeReq  out  1  one-cycle pulse; newPipe was consumed, so the generator must advance.
- running  out  1  high in RUN.
- crashed  out  1  high in CRASHED.
- score  out  8  pipes passed, saturating.

## Operation
- Storage: col[0..COLS-1], 16 bits each. spaceCnt is 4 bits. score is 8 bits.
- States:
  - IDLE: running=0, crashed=0.
  - RUN: running=1, crashed=0.
  - CRASHED: running=0, crashed=1.
- IDLE, or CRASHED with start=1, goes to RUN. On that edge it also clears every column to 16'h0000, sets score=0, and sets spaceCnt=GAP_COLS.
- In RUN, start is ignored. In IDLE and CRASHED, tick is ignored.
- hit = col[BIRD_COL][birdRow], evaluated only in RUN.
- RUN with hit=1 goes to CRASHED on the next edge. On that edge there is no shift, no score change, and no pipeReq, even if tick=1.
- RUN with hit=0 and tick=1 performs a scroll:
  - col[i] ← col[i+1] for i=0..COLS-2.
  - If spaceCnt==0: col[COLS-1] ← newPipe, spaceCnt ← GAP_COLS, pipeReq=1 for exactly that edge.
  - Otherwise: col[COLS-1] ← 16'h0000 and spaceCnt decrements.
  - If col[BIRD_COL] before the shift is nonzero, score increments. At 255, score holds 255.
- A pipe column is any nonzero column. Multi-column pipes are not supported; each pipe is one column wide.
- CRASHED freezes the field and score so they remain visible. Only start leaves CRASHED.
- rdData = col[rdCol] combinationally. If rdCol ≥ COLS, rdData = 16'h0000.

## Timing
- Reset values: state IDLE, all columns 16'h0000, spaceCnt=GAP_COLS, score=0, pipeReq=0, running=0, crashed=0.
- Reset asserted mid-game returns everything to these values immediately, independent of clk.
- All state updates occur on the rising clk edge on which start or tick is sampled high.
- pipeReq is registered. It is high for the cycle following the consuming edge, and the generator advances on that cycle.
- The first pipe enters col[COLS-1] on the (GAP_COLS+1)th tick after start. Later pipes follow every GAP_COLS+1 ticks.
- A pipe inserted on tick n is in col[BIRD_COL] after tick n+(COLS-1-BIRD_COL). It scores on the following tick.
- Collision latency: crashed rises on the first edge at which hit=1 is sampled. Changes to birdRow are therefore checked every cycle, not only on ticks.
- tick=1 and start=1 in the same cycle while in IDLE or CRASHED: start wins and no scroll occurs.

## Test plan
- Reset: drive reset=0 mid-RUN with a nonzero field → all outputs and rdData are 0 and the state is IDLE before the next clk edge.
- Spawn cadence: start, then newPipe=16'hF01F with 5 ticks → pipeReq pulses once, on tick 4; rdCol=15 reads 16'hF01F; rdCol=14 reads 16'h0000.
- Pass/score: birdRow=7, continue ticking the same stream → after tick 16 rdCol=3 reads 16'hF01F; after tick 17 score=1 and running=1.
- Collision: same stream with birdRow=0 → crashed=1 on the edge after tick 16. An extra tick leaves col[3]=16'hF01F and score=0.
- Crash vs tick: birdRow changes into a lit cell in the same cycle as tick → no shift, crashed=1, no pipeReq.
- Restart and saturation: force 300 passes → score=255. Then start in CRASHED → field cleared, score=0, running=1; a tick in that same cycle causes no scroll.
